// File: rtl/multicycle_alu.sv
// Registered ALU: single-cycle data-processing ops plus iterative MUL/UDIV/UREM (WIDTH+1 cycles).
// Define ALU_SDIV_EN to turn opcode 1111 into a signed divide; otherwise 1111 acts as MOV.
module multicycle_alu #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Start,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] Src_A,
   input  logic [WIDTH-1:0] Src_B,
   input  logic             Carry,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ALUResult,
   output logic [3:0]       ALUFlags,
   output logic [1:0]       dbg_state_o
);

   // Handshake: Start is taken on a rising edge only while Busy=0; Done is a one-cycle
   // pulse in the cycle ALUResult/ALUFlags take their new value, which then holds.

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_ORR  = 4'b0011;
   localparam logic [3:0] OP_ADC  = 4'b0100;
   localparam logic [3:0] OP_EOR  = 4'b0101;
   localparam logic [3:0] OP_BIC  = 4'b0110;
   localparam logic [3:0] OP_MVN  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_RSB  = 4'b1001;
   localparam logic [3:0] OP_RSC  = 4'b1010;
   localparam logic [3:0] OP_SBC  = 4'b1011;
   localparam logic [3:0] OP_UDIV = 4'b1100;
   localparam logic [3:0] OP_UREM = 4'b1110;
`ifdef ALU_SDIV_EN
   localparam logic [3:0] OP_SDIV = 4'b1111;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             bzero_q, bzero_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;
`ifdef ALU_SDIV_EN
   logic             neg_q, neg_d;
   logic             ovf_q, ovf_d;
`endif

   logic             is_multi;
   logic             arith;
   logic [WIDTH-1:0] add_x, add_y;
   logic             add_cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] logic_res;
   logic [WIDTH-1:0] sc_res;
   logic [3:0]       sc_flags;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] fin_res;
   logic             fin_v;

`ifdef ALU_SDIV_EN
   assign is_multi = (ALUControl == OP_MUL) || (ALUControl == OP_UDIV) ||
                     (ALUControl == OP_UREM) || (ALUControl == OP_SDIV);
`else
   assign is_multi = (ALUControl == OP_MUL) || (ALUControl == OP_UDIV) ||
                     (ALUControl == OP_UREM);
`endif

   // One shared adder; every arithmetic opcode is expressed as x + y + cin so C and V
   // always come from the effective operands.
   always_comb begin
      add_x     = Src_A;
      add_y     = Src_B;
      add_cin   = 1'b0;
      arith     = 1'b1;
      logic_res = Src_B;
      case (ALUControl)
         OP_ADD:  ;
         OP_SUB:  begin add_y = ~Src_B; add_cin = 1'b1;  end
         OP_ADC:  add_cin = Carry;
         OP_RSB:  begin add_x = Src_B; add_y = ~Src_A; add_cin = 1'b1;  end
         OP_RSC:  begin add_x = Src_B; add_y = ~Src_A; add_cin = Carry; end
         OP_SBC:  begin add_y = ~Src_B; add_cin = Carry; end
         default: arith = 1'b0;
      endcase
      case (ALUControl)
         OP_AND:  logic_res = Src_A & Src_B;
         OP_ORR:  logic_res = Src_A | Src_B;
         OP_EOR:  logic_res = Src_A ^ Src_B;
         OP_BIC:  logic_res = Src_A & ~Src_B;
         OP_MVN:  logic_res = ~Src_B;
         default: logic_res = Src_B;
      endcase
      sum      = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
      sc_res   = arith ? sum[WIDTH-1:0] : logic_res;
      sc_flags = {sc_res[WIDTH-1],
                  sc_res == '0,
                  arith ? sum[WIDTH] : Carry,
                  arith & (add_x[WIDTH-1] == add_y[WIDTH-1]) & (sum[WIDTH-1] != add_x[WIDTH-1])};
   end

   // Restoring divide: a_q shifts the dividend out while quotient bits shift in.
   assign rem_shift = {acc_q, a_q[WIDTH-1]};

   // With B==0 every step subtracts zero, so acc_q ends holding A: that is the UREM result.
   always_comb begin
      fin_res = acc_q;
      fin_v   = flags_q[0];
      case (op_q)
         OP_UDIV: begin
            fin_res = bzero_q ? '1 : a_q;
            fin_v   = flags_q[0] | bzero_q;
         end
         OP_UREM: fin_v = flags_q[0] | bzero_q;
`ifdef ALU_SDIV_EN
         OP_SDIV: begin
            fin_res = bzero_q ? '0 : (neg_q ? -a_q : a_q);
            fin_v   = flags_q[0] | bzero_q | ovf_q;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      bzero_d  = bzero_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      flags_d  = flags_q;
`ifdef ALU_SDIV_EN
      neg_d    = neg_q;
      ovf_d    = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               op_d = ALUControl;
               if (is_multi) begin
                  state_d = S_ITER;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
                  acc_d   = '0;
                  a_d     = Src_A;
                  b_d     = Src_B;
                  bzero_d = (Src_B == '0);
`ifdef ALU_SDIV_EN
                  neg_d   = 1'b0;
                  ovf_d   = 1'b0;
                  if (ALUControl == OP_SDIV) begin
                     a_d   = Src_A[WIDTH-1] ? -Src_A : Src_A;
                     b_d   = Src_B[WIDTH-1] ? -Src_B : Src_B;
                     neg_d = Src_A[WIDTH-1] ^ Src_B[WIDTH-1];
                     ovf_d = (Src_A == {1'b1, {(WIDTH-1){1'b0}}}) && (Src_B == '1);
                  end
`endif
               end else begin
                  result_d = sc_res;
                  flags_d  = sc_flags;
                  done_d   = 1'b1;
               end
            end
         end
         S_ITER: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (op_q == OP_MUL) begin
               if (b_q[0]) acc_d = acc_q + a_q;
               a_d = a_q << 1;
               b_d = b_q >> 1;
            end else if (rem_shift >= {1'b0, b_q}) begin
               acc_d = rem_shift[WIDTH-1:0] - b_q;
               a_d   = {a_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = rem_shift[WIDTH-1:0];
               a_d   = {a_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIN;
         end
         S_FIN: begin
            result_d = fin_res;
            flags_d  = {fin_res[WIDTH-1], fin_res == '0, flags_q[1], fin_v};
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         bzero_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
`ifdef ALU_SDIV_EN
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         bzero_q  <= bzero_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         flags_q  <= flags_d;
`ifdef ALU_SDIV_EN
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign Busy        = busy_q;
   assign Done        = done_q;
   assign ALUResult   = result_q;
   assign ALUFlags    = flags_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: vector table, multi-cycle corner sequences, WIDTH=8 instance.
`timescale 1ns/1ps
module tb_multicycle_alu;

   localparam int W = 32;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] res;
      logic [3:0]   flg;
   } vec_t;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         Start;
   logic [3:0]   ALUControl;
   logic [W-1:0] Src_A, Src_B;
   logic         Carry;
   logic         Busy, Done;
   logic [W-1:0] ALUResult;
   logic [3:0]   ALUFlags;
   logic [1:0]   dbg_state;

   logic         start8;
   logic [3:0]   op8;
   logic [7:0]   a8, b8;
   logic         busy8, done8;
   logic [7:0]   res8;
   logic [3:0]   flags8;
   logic [1:0]   dbg8;

   int           checks = 0;
   int           errors = 0;
   logic [W+3:0] exp_q[$];
   vec_t         vecs[$];
   logic [3:0]   mflags;

   always #5 CLK = ~CLK;

   multicycle_alu #(.WIDTH(W)) u_dut (
      .CLK(CLK), .RESET(RESET), .Start(Start), .ALUControl(ALUControl),
      .Src_A(Src_A), .Src_B(Src_B), .Carry(Carry), .Busy(Busy), .Done(Done),
      .ALUResult(ALUResult), .ALUFlags(ALUFlags), .dbg_state_o(dbg_state)
   );

   multicycle_alu #(.WIDTH(8)) u_dut8 (
      .CLK(CLK), .RESET(RESET), .Start(start8), .ALUControl(op8),
      .Src_A(a8), .Src_B(b8), .Carry(1'b0), .Busy(busy8), .Done(done8),
      .ALUResult(res8), .ALUFlags(flags8), .dbg_state_o(dbg8)
   );

   function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic [W-1:0] res, input logic [3:0] flg);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.cin = cin; v.res = res; v.flg = flg;
      return v;
   endfunction

   function automatic bit is_multi_op(input logic [3:0] op);
`ifdef ALU_SDIV_EN
      return (op == 4'b1000) || (op == 4'b1100) || (op == 4'b1110) || (op == 4'b1111);
`else
      return (op == 4'b1000) || (op == 4'b1100) || (op == 4'b1110);
`endif
   endfunction

   // Reference for the random ops (carry-in fixed at 0): ADD, EOR, MUL, UDIV, UREM.
   function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [3:0] pf);
      logic [W:0]   s;
      logic [W-1:0] r;
      logic         c, v;
      c = pf[1];
      v = pf[0];
      r = '0;
      case (op)
         4'b0000: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0];
            c = s[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         4'b0101: begin r = a ^ b; c = 1'b0; v = 1'b0; end
         4'b1000: r = a * b;
         4'b1100: r = a / b;
         default: r = a % b;
      endcase
      return {r, r[W-1], r == '0, c, v};
   endfunction

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic score(input string name);
      logic [W+3:0] exp;
      checks++;
      exp = exp_q.pop_front();
      if (!Done) begin
         errors++;
         $display("FAIL %s: no Done within budget, expected res/flags %h", name, exp);
      end else if ({ALUResult, ALUFlags} !== exp) begin
         errors++;
         $display("FAIL %s: got res %h flags %b expected res %h flags %b",
                  name, ALUResult, ALUFlags, exp[W+3:4], exp[3:0]);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
      @(negedge CLK);
      Start = 1'b1; ALUControl = op; Src_A = a; Src_B = b; Carry = cin;
      @(posedge CLK); #1;
      Start = 1'b0;
   endtask

   // Returns edges after the Start edge until Done, and Busy samples in the first W of them.
   task automatic wait_done(input int limit, input bit poke, output int n, output int busy_hi);
      n = 0;
      busy_hi = 0;
      while (!Done && n < limit) begin
         if (n < W && Busy) busy_hi++;
         if (poke && n == 10) begin
            Start = 1'b1; ALUControl = 4'b0000; Src_A = 32'd1; Src_B = 32'd1;
         end
         if (poke && n == 11) Start = 1'b0;
         @(posedge CLK); #1;
         n++;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int n, bh;
      exp_q.push_back({v.res, v.flg});
      issue(v.op, v.a, v.b, v.cin);
      wait_done(3 * W, 1'b0, n, bh);
      score($sformatf("vec%0d", idx));
      check_int($sformatf("vec%0d_lat", idx), n, is_multi_op(v.op) ? W + 1 : 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, bh, seen;
      logic [3:0]   rop;
      logic [W-1:0] ra, rb;
      logic [W+3:0] e;

      RESET = 1'b1; Start = 1'b0; ALUControl = '0; Src_A = '0; Src_B = '0; Carry = 1'b0;
      start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;

      vecs.push_back(mk(4'b0000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b1001));
      vecs.push_back(mk(4'b0100, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b0110));
      vecs.push_back(mk(4'b1011, 32'd5,        32'd3,        1'b0, 32'd1,        4'b0010));
      vecs.push_back(mk(4'b0001, 32'd3,        32'd5,        1'b0, 32'hFFFFFFFE, 4'b1000));
      vecs.push_back(mk(4'b1001, 32'd1,        32'd10,       1'b0, 32'd9,        4'b0010));
      vecs.push_back(mk(4'b1010, 32'd1,        32'd10,       1'b0, 32'd8,        4'b0010));
      vecs.push_back(mk(4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 4'b1010));
      vecs.push_back(mk(4'b0011, 32'h0,        32'h0,        1'b0, 32'h0,        4'b0100));
      vecs.push_back(mk(4'b0101, 32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 4'b1000));
      vecs.push_back(mk(4'b0110, 32'hFFFFFFFF, 32'h0000FFFF, 1'b1, 32'hFFFF0000, 4'b1010));
      vecs.push_back(mk(4'b0111, 32'h0,        32'hFFFFFFFF, 1'b1, 32'h0,        4'b0110));
      vecs.push_back(mk(4'b1101, 32'h0,        32'h12345678, 1'b0, 32'h12345678, 4'b0000));
`ifndef ALU_SDIV_EN
      vecs.push_back(mk(4'b1111, 32'h1,        32'h80000000, 1'b1, 32'h80000000, 4'b1010));
`endif
      vecs.push_back(mk(4'b0000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0,        4'b0110));
      vecs.push_back(mk(4'b1100, 32'd100,      32'd7,        1'b0, 32'd14,       4'b0010));
      vecs.push_back(mk(4'b1110, 32'd100,      32'd7,        1'b0, 32'd2,        4'b0010));
      vecs.push_back(mk(4'b1100, 32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 4'b1011));
      vecs.push_back(mk(4'b1110, 32'd9,        32'd0,        1'b0, 32'd9,        4'b0011));
      vecs.push_back(mk(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1,        4'b0011));
      vecs.push_back(mk(4'b0000, 32'h0,        32'h0,        1'b0, 32'h0,        4'b0100));
      vecs.push_back(mk(4'b1000, 32'd12345,    32'd0,        1'b0, 32'h0,        4'b0100));
      vecs.push_back(mk(4'b1100, 32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 4'b1000));
      vecs.push_back(mk(4'b1100, 32'd7,        32'd100,      1'b0, 32'h0,        4'b0100));
      vecs.push_back(mk(4'b1110, 32'hDEADBEEF, 32'h00010000, 1'b0, 32'h0000BEEF, 4'b0000));

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      check_int("rst_result", int'(ALUResult), 0);
      check_int("rst_flags", int'(ALUFlags), 0);
      check_int("rst_busy", int'(Busy), 0);
      check_int("rst_done", int'(Done), 0);
      check_int("rst_state", int'(dbg_state), 0);
      @(negedge CLK);
      RESET = 1'b0;

      // Table; multi-cycle ops directly followed by single-cycle ops exercise back-to-back Start
      foreach (vecs[i]) run_vec(vecs[i], i);

      // MUL latency, Busy window, and a Start mid-operation that must be ignored
      exp_q.push_back({32'h00020001, 4'b0000});
      issue(4'b1000, 32'h00010001, 32'h00010001, 1'b0);
      wait_done(3 * W, 1'b1, n, bh);
      score("mul_seq");
      check_int("mul_lat", n, W + 1);
      check_int("mul_busy", bh, W);
      check_int("mul_busy_clr", int'(Busy), 0);
      @(posedge CLK); #1;
      check_int("mul_done_pulse", int'(Done), 0);
      check_int("mul_hold", int'(ALUResult), 32'h00020001);

      // Random ops against the reference model
      mflags = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         case ($urandom_range(0, 4))
            0:       rop = 4'b0000;
            1:       rop = 4'b0101;
            2:       rop = 4'b1000;
            3:       rop = 4'b1100;
            default: rop = 4'b1110;
         endcase
         ra = $urandom();
         rb = (rop == 4'b1100 || rop == 4'b1110) ? W'($urandom_range(1, 32'h0000FFFF)) : $urandom();
         e = model(rop, ra, rb, mflags);
         mflags = e[3:0];
         run_vec(mk(rop, ra, rb, 1'b0, e[W+3:4], e[3:0]), 100 + i);
      end

      // Reset in the middle of a MUL aborts it without a Done pulse
      issue(4'b1000, 32'd3, 32'd3, 1'b0);
      repeat (10) begin @(posedge CLK); #1; end
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK); #1;
      check_int("abort_busy", int'(Busy), 0);
      check_int("abort_done", int'(Done), 0);
      check_int("abort_result", int'(ALUResult), 0);
      check_int("abort_state", int'(dbg_state), 0);
      @(negedge CLK);
      RESET = 1'b0;
      seen = 0;
      repeat (2 * W) begin
         @(posedge CLK); #1;
         if (Done) seen++;
      end
      check_int("abort_no_done", seen, 0);
      run_vec(mk(4'b0000, 32'd2, 32'd2, 1'b0, 32'd4, 4'b0000), 200);

`ifdef ALU_SDIV_EN
      run_vec(mk(4'b1111, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 4'b1000), 300);
      run_vec(mk(4'b1111, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 4'b1001), 301);
      run_vec(mk(4'b1111, 32'd7,        32'd0,        1'b0, 32'h0,        4'b0101), 302);
      run_vec(mk(4'b1111, 32'd100,      32'hFFFFFFF9, 1'b0, 32'hFFFFFFF2, 4'b1001), 303);
`endif

      // WIDTH=8 instance: product wraps to zero
      @(negedge CLK);
      start8 = 1'b1; op8 = 4'b1000; a8 = 8'h10; b8 = 8'h10;
      @(posedge CLK); #1;
      start8 = 1'b0;
      n = 0;
      while (!done8 && n < 100) begin
         @(posedge CLK); #1;
         n++;
      end
      check_int("w8_mul", int'({done8, res8, flags8}), 'h1004);
      check_int("w8_lat", n, 9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, registered successor to the processor's combinational ALU.
- Executes the existing 4-bit ALUControl data-processing set in one cycle.
- Adds iterative unsigned multiply, divide and remainder that take WIDTH+1 cycles.
- Sits in the Execute stage; the control unit stalls on Busy and captures ALUResult/ALUFlags on Done.

Parameters:
- WIDTH, 32: operand/result width in bits; legal range 8..64.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, not overridden.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only when Busy=0.
- ALUControl  input  4  opcode; latched with Start.
- Src_A  input  WIDTH  operand A; latched with Start.
- Src_B  input  WIDTH  operand B; latched with Start.
- Carry  input  1  C flag in; latched with Start.
- Busy  output  1  high while a multi-cycle op is in flight.
- Done  output  1  one-cycle pulse; result valid.
- ALUResult  output  WIDTH  registered result; held until the next Done.
- ALUFlags  output  4  registered {N,Z,C,V}; held until the next Done.

Behaviour:
- Reset (sync, active-high):
  - Busy=0, Done=0, ALUResult=0, ALUFlags=0000, FSM=IDLE, counter=0.
  - Reset asserted mid-operation aborts the op; no Done pulse is produced.
- FSM states: IDLE, ITER, FIN.
  - IDLE: on Start=1, latch inputs. A single-cycle opcode writes the result and flags and pulses Done on the next edge; the FSM stays in IDLE. A multi-cycle opcode sets Busy=1, counter=0 and goes to ITER.
  - ITER: one shift-add or restoring-divide step per cycle; counter increments. At counter==WIDTH-1, go to FIN.
  - FIN: write result and flags, pulse Done, clear Busy, go to IDLE.
  - Multi-cycle latency is Start edge to Done = WIDTH+1 cycles.
- Back-to-back:
  - Start with Busy=0 in the same cycle as Done is accepted.
  - Start while Busy=1 is ignored; there is no queueing.
- Single-cycle opcodes (full WIDTH+1-bit sum; C = bit WIDTH):
  - 0000 ADD: A+B
  - 0001 SUB: A+~B+1
  - 0010 AND
  - 0011 ORR
  - 0100 ADC: A+B+Carry, carry included in the single adder, so C is correct.
  - 0101 EOR
  - 0110 BIC: A&~B
  - 0111 MVN: ~B
  - 1001 RSB: B+~A+1
  - 1010 RSC: B+~A+Carry
  - 1011 SBC: A+~B+Carry
  - 1101 MOV: B
- Single-cycle flags:
  - V is computed for arithmetic opcodes from the operand sign bits and the result sign, relative to the effective operands.
  - Logical/move opcodes: C = latched Carry, V = 0.
  - N = result MSB; Z = (result==0).
- Multi-cycle opcodes:
  - 1000 MUL: low WIDTH bits of unsigned A*B.
  - 1100 UDIV: unsigned A/B.
  - 1110 UREM: unsigned A%B.
  - N and Z come from the result; C and V are taken from the previous ALUFlags value (unchanged).
- Divide by zero (B==0):
  - UDIV result = all ones; UREM result = A.
  - V=1. This is the only case where MUL/DIV modify a flag other than N and Z.
  - Full WIDTH+1-cycle latency still applies.
- Undefined opcodes (1111 when ALU_SDIV_EN is not defined):
  - Treated as single-cycle MOV; C = Carry, V = 0.
- Outputs are pure register outputs; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: ALU_SDIV_EN.
- Defined: opcode 1111 = SDIV, two's-complement signed divide truncating toward zero.
  - Operands are converted to magnitudes in IDLE; the quotient sign is fixed up in FIN.
  - Latency is WIDTH+1 cycles.
  - Divide by zero gives result 0 and V=1.
  - The most-negative value divided by -1 gives result = the most-negative value and V=1.
- Not defined: no sign logic is synthesised; 1111 behaves as MOV.

Test Plan:
- Reset/ADD: hold RESET 2 cycles. Expect ALUResult=0, Flags=0000, Busy=0. Then ADD 0x7FFFFFFF+0x00000001 → one cycle later Done=1, result 0x80000000, Flags N=1 Z=0 C=0 V=1.
- ADC/SBC carry: ADC 0xFFFFFFFF+0x00000000 with Carry=1 → result 0, Flags 0110. SBC 5-3 with Carry=0 → result 1, C=1, V=0.
- MUL latency: MUL 0x00010001*0x00010001 → Busy high for 32 cycles, Done exactly 33 cycles after Start, result 0x00020001. A Start pulse issued mid-operation is ignored.
- UDIV/UREM: UDIV 100/7 → 14; UREM 100/7 → 2. UDIV 5/0 → 0xFFFFFFFF with V=1, and C is unchanged from the prior op.
- Reset abort: start MUL, assert RESET at cycle 10 → no Done pulse, Busy=0 next cycle. A subsequent ADD 2+2 returns 4.
- With ALU_SDIV_EN defined: SDIV -7/2 → 0xFFFFFFFD. SDIV 0x80000000/0xFFFFFFFF → 0x80000000 with V=1. WIDTH=8 build: MUL 0x10*0x10 → 0x00 with Z=1.
